// File: rtl/mips32_fetch_buffer_if.sv
// Bus bundle between the fetch buffer, instruction memory and the IF stage.
// master = fetch buffer side, slave = memory / IF-stage side.
interface mips32_fetch_buffer_if #(
  parameter int AW = 10
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          ir_valid;
  logic [31:0]   ir_data;
  logic [31:0]   ir_npc;
  logic          ir_ready;

  modport master (
    output imem_req, imem_addr, ir_valid, ir_data, ir_npc,
    input  imem_ack, imem_rdata, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_data, ir_npc,
    output imem_ack, imem_rdata, ir_ready
  );
endinterface

// File: rtl/mips32_fetch_buffer.sv
// Instruction prefetch FIFO ahead of the mips32_core IF stage.
// Optional MIPS32_FB_HLT_STOP_EN: stop prefetching after a HLT word is pushed.
//
// state | meaning
// IDLE  | no request outstanding
// REQ   | request at fetch_pc outstanding; ack data is pushed
// DROP  | stale request (pre-redirect) outstanding; ack data is discarded
module mips32_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   halted,
  mips32_fetch_buffer_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, fetch_pc_nx;
  logic [AW-1:0] drop_addr, drop_addr_nx;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_npc  [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          hlt_seen, hlt_seen_nx;
  logic          push, pop, issue, head_valid;

  assign head_valid = (count != '0);
  assign pop        = head_valid && bus.ir_ready && !redirect;

  always_comb begin
    state_nx     = state;
    fetch_pc_nx  = fetch_pc;
    drop_addr_nx = drop_addr;
    count_nx     = count;
    hlt_seen_nx  = hlt_seen;
    push         = (state == REQ) && bus.imem_ack && !redirect;

    if (redirect) begin
      count_nx    = '0;
      fetch_pc_nx = redirect_pc;
      hlt_seen_nx = 1'b0;
    end else begin
      if (push) fetch_pc_nx = fetch_pc + 32'd1;
      case ({push, pop})
        2'b10:   count_nx = count + CW'(1);
        2'b01:   count_nx = count - CW'(1);
        default: count_nx = count;
      endcase
`ifdef MIPS32_FB_HLT_STOP_EN
      if (push && (bus.imem_rdata[31:26] == 6'b111111)) hlt_seen_nx = 1'b1;
`endif
    end

    // Issue decision looks at post-update occupancy so a pop this cycle
    // lets the next request go out immediately.
    issue = (count_nx < FULL) && !halted && !hlt_seen_nx;

    case (state)
      IDLE: if (issue) state_nx = REQ;
      REQ: begin
        if (bus.imem_ack) begin
          state_nx = issue ? REQ : IDLE;
        end else if (redirect) begin
          state_nx     = DROP;
          drop_addr_nx = fetch_pc[AW-1:0];
        end
      end
      DROP: if (bus.imem_ack) state_nx = issue ? REQ : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_nx;
      fetch_pc  <= fetch_pc_nx;
      drop_addr <= drop_addr_nx;
      count     <= count_nx;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

`ifdef MIPS32_FB_HLT_STOP_EN
  always_ff @(posedge clk1) begin
    if (rst) hlt_seen <= 1'b0;
    else     hlt_seen <= hlt_seen_nx;
  end
`else
  assign hlt_seen = 1'b0;
`endif

  always_ff @(posedge clk1) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.imem_rdata;
      fifo_npc[wr_ptr]  <= fetch_pc + 32'd1;
    end
  end

  // The outstanding address must not move while DROP waits for its ack.
  assign bus.imem_req  = (state != IDLE);
  assign bus.imem_addr = (state == DROP) ? drop_addr : fetch_pc[AW-1:0];
  assign bus.ir_valid  = head_valid;
  assign bus.ir_data   = head_valid ? fifo_data[rd_ptr] : 32'd0;
  assign bus.ir_npc    = head_valid ? fifo_npc[rd_ptr]  : 32'd0;
endmodule

// File: tb/tb_mips32_fetch_buffer.sv
// Directed bench for mips32_fetch_buffer with a variable-latency memory model.
`timescale 1ns/1ps
module tb_mips32_fetch_buffer;
  localparam int AW = 10;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halted = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] mem [1024];
  int          wait_states = 0;
  int          wait_cnt = 0;
  int          ack_count = 0;
  int          ack_base;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk1 = ~clk1;

  mips32_fetch_buffer_if #(.AW(AW)) bus ();

  mips32_fetch_buffer #(.DEPTH(4), .AW(AW), .RESET_PC(32'd0)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .bus         (bus)
  );

  assign bus.imem_ack   = bus.imem_req && (wait_cnt >= wait_states);
  assign bus.imem_rdata = mem[bus.imem_addr];
  assign bus.ir_ready   = ready;

  always @(posedge clk1) begin
    if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else                               wait_cnt <= wait_cnt + 1;
    if (bus.imem_req && bus.imem_ack) ack_count <= ack_count + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Leaves the bench in the first cycle after the reset edge, rst already low.
  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    halted = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + i;

    // streaming with zero-wait memory
    ready = 1'b1;
    wait_states = 0;
    do_reset();
    check_val("rst_req",   32'(bus.imem_req), 32'd0);
    check_val("rst_addr",  32'(bus.imem_addr), 32'd0);
    check_val("rst_valid", 32'(bus.ir_valid), 32'd0);
    check_val("rst_data",  bus.ir_data, 32'd0);
    check_val("rst_npc",   bus.ir_npc, 32'd0);
    tick();
    check_val("s_first_req",   32'(bus.imem_req), 32'd1);
    check_val("s_first_addr",  32'(bus.imem_addr), 32'd0);
    check_val("s_first_valid", 32'(bus.ir_valid), 32'd0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      check_val("s_addr", 32'(bus.imem_addr), 32'(k - 1));
      check_val("s_data", bus.ir_data, 32'h100 + 32'(k - 2));
      check_val("s_npc",  bus.ir_npc, 32'(k - 1));
    end

    // backpressure fills the FIFO, then resume
    ready = 1'b0;
    do_reset();
    ack_base = ack_count;
    for (int k = 0; k < 8; k++) tick();
    check_val("bp_acks", 32'(ack_count - ack_base), 32'd4);
    check_val("bp_req",  32'(bus.imem_req), 32'd0);
    check_val("bp_data", bus.ir_data, 32'h100);
    check_val("bp_npc",  bus.ir_npc, 32'd1);
    ready = 1'b1;
    tick();
    check_val("bp_resume_req",  32'(bus.imem_req), 32'd1);
    check_val("bp_resume_addr", 32'(bus.imem_addr), 32'd4);
    check_val("bp_resume_data", bus.ir_data, 32'h101);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("bp_seq_data", bus.ir_data, 32'h102 + 32'(k));
      check_val("bp_seq_npc",  bus.ir_npc, 32'd3 + 32'(k));
    end

    // redirect during a slow request
    ready = 1'b1;
    wait_states = 2;
    do_reset();
    tick();
    check_val("rd_req0", 32'(bus.imem_ack), 32'd0);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check_val("rd_stale_addr", 32'(bus.imem_addr), 32'd0);
    check_val("rd_stale_req",  32'(bus.imem_req), 32'd1);
    check_val("rd_valid3",     32'(bus.ir_valid), 32'd0);
    tick();
    check_val("rd_new_addr", 32'(bus.imem_addr), 32'h40);
    check_val("rd_valid4",   32'(bus.ir_valid), 32'd0);
    tick();
    check_val("rd_valid5", 32'(bus.ir_valid), 32'd0);
    tick();
    check_val("rd_valid6", 32'(bus.ir_valid), 32'd0);
    tick();
    check_val("rd_valid7", 32'(bus.ir_valid), 32'd1);
    check_val("rd_data",   bus.ir_data, 32'h140);
    check_val("rd_npc",    bus.ir_npc, 32'h41);

    // redirect, ack and pop in one cycle with two entries held
    ready = 1'b0;
    wait_states = 0;
    do_reset();
    tick();
    tick();
    tick();
    check_val("co_pre_valid", 32'(bus.ir_valid), 32'd1);
    check_val("co_pre_ack",   32'(bus.imem_ack), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    ready = 1'b1;
    tick();
    redirect = 1'b0;
    check_val("co_valid", 32'(bus.ir_valid), 32'd0);
    check_val("co_req",   32'(bus.imem_req), 32'd1);
    check_val("co_addr",  32'(bus.imem_addr), 32'h200);
    tick();
    check_val("co_data", bus.ir_data, 32'h300);
    check_val("co_npc",  bus.ir_npc, 32'h201);

    // halt while a request is pending
    ready = 1'b0;
    wait_states = 2;
    do_reset();
    ack_base = ack_count;
    tick();
    halted = 1'b1;
    tick();
    check_val("h_pending_req", 32'(bus.imem_req), 32'd1);
    tick();
    tick();
    check_val("h_req_off", 32'(bus.imem_req), 32'd0);
    check_val("h_valid",   32'(bus.ir_valid), 32'd1);
    check_val("h_data",    bus.ir_data, 32'h100);
    ready = 1'b1;
    tick();
    check_val("h_drained", 32'(bus.ir_valid), 32'd0);
    tick();
    check_val("h_req_still_off", 32'(bus.imem_req), 32'd0);
    check_val("h_acks", 32'(ack_count - ack_base), 32'd1);
    halted = 1'b0;

    // HLT word in the stream
    mem[3] = 32'hFC00_0000;
    ready = 1'b1;
    wait_states = 0;
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    check_val("hlt_data", bus.ir_data, 32'hFC00_0000);
`ifdef MIPS32_FB_HLT_STOP_EN
    check_val("hlt_stop_req", 32'(bus.imem_req), 32'd0);
    tick();
    tick();
    check_val("hlt_idle_req",   32'(bus.imem_req), 32'd0);
    check_val("hlt_idle_valid", 32'(bus.ir_valid), 32'd0);
`else
    check_val("hlt_cont_req",  32'(bus.imem_req), 32'd1);
    check_val("hlt_cont_addr", 32'(bus.imem_addr), 32'd4);
    tick();
    tick();
`endif
    redirect = 1'b1;
    redirect_pc = 32'd8;
    tick();
    redirect = 1'b0;
    check_val("hlt_redir_req",  32'(bus.imem_req), 32'd1);
    check_val("hlt_redir_addr", 32'(bus.imem_addr), 32'd8);
    tick();
    check_val("hlt_redir_data", bus.ir_data, 32'h108);
    check_val("hlt_redir_npc",  bus.ir_npc, 32'd9);
    mem[3] = 32'h103;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mips32_fetch_buffer.md
# mips32_fetch_buffer

Instruction prefetch queue that sits directly upstream of the `mips32_core` IF stage. It issues word-addressed reads to instruction memory over a req/ack handshake and buffers the returned words with their next-PC values in a DEPTH-entry FIFO. The IF stage pops one entry per accepted instruction. On a taken branch or JAL redirect, the FIFO is flushed, stale in-flight data is discarded, and fetching restarts at the target.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `AW`, 10: instruction memory word-address width (1024 words).
- `RESET_PC`, 0: first fetch address after reset.
- `clk1`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `redirect`  in  1  branch or JAL taken; flush the FIFO and restart fetch.
- `redirect_pc`  in  32  target word address; sampled when `redirect`=1.
- `halted`  in  1  core halted; no new memory requests are issued.
- `imem_req`  out  1  read request.
- `imem_addr`  out  AW  word address; equals `fetch_pc[AW-1:0]`.
- `imem_ack`  in  1  read done; `imem_rdata` is valid in this cycle. May assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `ir_valid`  out  1  FIFO head is valid.
- `ir_data`  out  32  head instruction; 0 when `ir_valid`=0.
- `ir_npc`  out  32  head PC+1; 0 when `ir_valid`=0.
- `ir_ready`  in  1  pop the head; ignored when `ir_valid`=0.

## Operation
- Internal state:
  - `fetch_pc` (32 bits).
  - FIFO storage with `wr_ptr`/`rd_ptr` wrapping modulo DEPTH.
  - `count` ($clog2(DEPTH)+1 bits).
  - FSM `{IDLE, REQ, DROP}`.
- Request rules:
  - At most one request is outstanding at a time.
  - `imem_req` and `imem_addr` stay stable from assertion until `imem_ack`.
- IDLE, `imem_req`=0:
  - Go to REQ when `count<DEPTH`, `halted`=0, and no stop condition holds.
- REQ, `imem_req`=1:
  - On `imem_ack`: push {`imem_rdata`, `fetch_pc`+1} and increment `fetch_pc`.
  - Stay in REQ if the issue condition still holds after the push; otherwise go to IDLE.
  - `count` cannot reach DEPTH while a request is pending, because a request is only issued when `count<DEPTH`, so a push never overflows.
- DROP, `imem_req`=1, address is the stale one:
  - On `imem_ack`: discard the data and go to REQ (or to IDLE if `halted`).
- Redirect, `redirect`=1:
  - Flush: `count`, `wr_ptr` and `rd_ptr` go to 0.
  - Set `fetch_pc` to `redirect_pc`.
  - Next state from REQ without ack: DROP. From DROP without ack: stay in DROP, using the newest `redirect_pc`.
  - Next state from REQ or DROP with ack: discard the data and go to REQ.
  - Next state from IDLE: REQ.
- Simultaneous events:
  - Redirect beats both push and pop in the same cycle.
  - Push and pop together leave `count` unchanged.
- `halted` only blocks new requests. A pending request still completes and is pushed; the FIFO drains normally.
- PC arithmetic is 32-bit and wraps modulo 2^32. `imem_addr` uses the low AW bits.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=0, `ir_valid`=0, `ir_data`=0, `ir_npc`=0.
  - `fetch_pc`=RESET_PC, state IDLE, `count`=0.
- First request: `imem_req`=1 in the cycle after `rst` deasserts.
- Latency:
  - Ack in cycle t gives `ir_valid`=1 in cycle t+1.
  - Redirect in cycle t (no stale request pending) gives a request for the new address in cycle t+1.
- Throughput: 1 instruction per cycle with zero-wait memory and `ir_ready`=1.
- `ir_*` outputs are driven from the FIFO head register; there is no combinational path from `imem_rdata` to `ir_data`.

## Configuration
- `MIPS32_FB_HLT_STOP_EN` defined:
  - Pushing a word whose bits [31:26]=6'b111111 (HLT) sets `hlt_seen`.
  - While `hlt_seen`=1, the issue condition is false. The FSM goes to IDLE after that ack.
  - `hlt_seen` is cleared by `redirect` or `rst`.
- Macro undefined: HLT words are treated as ordinary data and prefetch continues.

## Test plan
- Reset with zero-wait memory (Mem[i]=0x100+i) and `ir_ready`=1 -> `imem_addr` 0,1,2,… on consecutive cycles; `ir_data` 0x100,0x101,… with `ir_npc` 1,2,…, one per cycle.
- `ir_ready`=0, DEPTH=4 -> exactly 4 acks, then `imem_req`=0 with `ir_data`=0x100; raising `ir_ready` resumes requests the next cycle with no lost or duplicated words.
- 3-cycle memory latency, `redirect`=1 with `redirect_pc`=0x40 in the 2nd wait cycle -> stale word never appears on `ir_data`; next request has `imem_addr`=0x40; first `ir_data`=Mem[0x40] with `ir_npc`=0x41.
- `redirect`, `imem_ack` and pop all in the same cycle with FIFO holding 2 entries -> `ir_valid`=0 the next cycle and `imem_addr`=`redirect_pc` the following cycle.
- `halted`=1 while a request is pending -> that ack is pushed, `imem_req`=0 afterwards, FIFO drains to `ir_valid`=0.
- Mem[3]=0xFC000000 -> with the macro, only addresses 0..3 are requested and a redirect to 8 resumes at 8; without the macro, address 4 is requested.
